// File: rtl/tea_round_ctrl.sv
// Iterative 8-bit TEA engine: one half-round per clock, encrypt or decrypt.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   start, E_D                     launch request and mode (0 enc, 1 dec)
//   Key0..Key3, V0, V1             key and data words, captured with start
//   busy, done                     in-progress flag and result strobe
//   aluResult0, aluResult1         result words, held until next done
module tea_round_ctrl #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [7:0]  DELTA  = 8'hB7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       E_D,
    input  logic [7:0] Key0,
    input  logic [7:0] Key1,
    input  logic [7:0] Key2,
    input  logic [7:0] Key3,
    input  logic [7:0] V0,
    input  logic [7:0] V1,
    output logic       busy,
    output logic       done,
    output logic [7:0] aluResult0,
    output logic [7:0] aluResult1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HALF_A = 2'd1,
        HALF_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Decrypt walks sum backwards from its final encrypt value.
    localparam int unsigned DPROD   = int'(DELTA) * ROUNDS;
    localparam logic [7:0]  SUM_DEC = DPROD[7:0];
    localparam logic [7:0]  RND8    = ROUNDS[7:0];

    state_t     state_q;
    logic       ed_q;
    logic [7:0] k0_q, k1_q, k2_q, k3_q;
    logic [7:0] v0_q, v1_q;
    logic [7:0] sum_q;
    logic [7:0] cnt_q;
    logic       busy_q, done_q;
    logic [7:0] res0_q, res1_q;

    logic [7:0] v0_d, v1_d, sum_d;
    logic [7:0] sum_inc, f01, f23, cnt_inc;

    function automatic logic [7:0] f_mix(
        input logic [7:0] x,
        input logic [7:0] s,
        input logic [7:0] ka,
        input logic [7:0] kb
    );
        logic [7:0] a, b, c;
        a = (x << 4) + ka;
        b = x + s;
        c = (x >> 5) + kb;
        return a ^ b ^ c;
    endfunction

    // Encrypt HALF_A and decrypt HALF_B share the (v1, Key0, Key1) mix;
    // only encrypt uses the freshly incremented sum there.
    assign sum_inc = sum_q + DELTA;
    assign f01     = f_mix(v1_q, ed_q ? sum_q : sum_inc, k0_q, k1_q);
    assign f23     = f_mix(v0_q, sum_q, k2_q, k3_q);
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        v0_d  = v0_q;
        v1_d  = v1_q;
        sum_d = sum_q;
        if (state_q == HALF_A) begin
            if (!ed_q) begin
                sum_d = sum_inc;
                v0_d  = v0_q + f01;
            end else begin
                v1_d  = v1_q - f23;
            end
        end else if (state_q == HALF_B) begin
            if (!ed_q) begin
                v1_d  = v1_q + f23;
            end else begin
                v0_d  = v0_q - f01;
                sum_d = sum_q - DELTA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ed_q    <= 1'b0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ed_q    <= E_D;
                        k0_q    <= Key0;
                        k1_q    <= Key1;
                        k2_q    <= Key2;
                        k3_q    <= Key3;
                        v0_q    <= V0;
                        v1_q    <= V1;
                        sum_q   <= E_D ? SUM_DEC : 8'd0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= HALF_A;
                    end
                end
                HALF_A: begin
                    v0_q    <= v0_d;
                    v1_q    <= v1_d;
                    sum_q   <= sum_d;
                    state_q <= HALF_B;
                end
                HALF_B: begin
                    v0_q  <= v0_d;
                    v1_q  <= v1_d;
                    sum_q <= sum_d;
                    cnt_q <= cnt_inc;
                    if (cnt_inc == RND8) begin
                        // Results take the values this edge produces.
                        res0_q  <= v0_d;
                        res1_q  <= v1_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= HALF_A;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aluResult0 = res0_q;
    assign aluResult1 = res1_q;

endmodule

// File: tb/tb_tea_round_ctrl.sv
// Scoreboard bench for tea_round_ctrl: dut 0 runs ROUNDS=1, dut 1 defaults.
// Stimulus pushes expectations; a negedge monitor pops them on each done.
module tb_tea_round_ctrl;

    typedef struct {
        logic [7:0] r0;
        logic [7:0] r1;
        int         t0;
        bit         lat;
        bit         gap;
    } exp_t;

    logic       clk;
    logic       rst   [2];
    logic       start [2];
    logic       ed    [2];
    logic [7:0] k0 [2];
    logic [7:0] k1 [2];
    logic [7:0] k2 [2];
    logic [7:0] k3 [2];
    logic [7:0] v0 [2];
    logic [7:0] v1 [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic [7:0] r0_w [2];
    logic [7:0] r1_w [2];

    exp_t sb [2][$];
    int   cyc;
    int   nvec;
    int   nerr;
    int   ndone [2];
    int   bcnt  [2];
    int   last_done [2];

    tea_round_ctrl #(.ROUNDS(1)) u_r1 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .E_D(ed[0]),
        .Key0(k0[0]), .Key1(k1[0]), .Key2(k2[0]), .Key3(k3[0]),
        .V0(v0[0]), .V1(v1[0]), .busy(busy_w[0]), .done(done_w[0]),
        .aluResult0(r0_w[0]), .aluResult1(r1_w[0])
    );

    tea_round_ctrl u_r32 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .E_D(ed[1]),
        .Key0(k0[1]), .Key1(k1[1]), .Key2(k2[1]), .Key3(k3[1]),
        .V0(v0[1]), .V1(v1[1]), .busy(busy_w[1]), .done(done_w[1]),
        .aluResult0(r0_w[1]), .aluResult1(r1_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    function automatic int rnd(input int d);
        return (d == 0) ? 1 : 32;
    endfunction

    function automatic logic [7:0] fm(
        input logic [7:0] x, input logic [7:0] s,
        input logic [7:0] ka, input logic [7:0] kb
    );
        logic [7:0] a, b, c;
        a = (x << 4) + ka;
        b = x + s;
        c = (x >> 5) + kb;
        return a ^ b ^ c;
    endfunction

    // Reference TEA with 8-bit words, plain loop form.
    function automatic logic [15:0] tea(
        input bit e, input int r,
        input logic [7:0] q0, input logic [7:0] q1,
        input logic [7:0] q2, input logic [7:0] q3,
        input logic [7:0] a0, input logic [7:0] b0
    );
        logic [7:0] s, a, b;
        int unsigned p;
        a = a0;
        b = b0;
        p = 32'hB7 * r;
        s = e ? p[7:0] : 8'd0;
        for (int i = 0; i < r; i++) begin
            if (!e) begin
                s = s + 8'hB7;
                a = a + fm(b, s, q0, q1);
                b = b + fm(a, s, q2, q3);
            end else begin
                b = b - fm(a, s, q2, q3);
                a = a - fm(b, s, q0, q1);
                s = s - 8'hB7;
            end
        end
        return {a, b};
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                bcnt[d] = 0;
            end else begin
                if (busy_w[d]) bcnt[d]++;
                if (done_w[d]) begin
                    exp_t e;
                    ndone[d]++;
                    if (sb[d].size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_done dut%0d: got %0h/%0h expected none",
                                 d, r0_w[d], r1_w[d]);
                    end else begin
                        e = sb[d].pop_front();
                        chk("result0", d, int'(r0_w[d]), int'(e.r0));
                        chk("result1", d, int'(r1_w[d]), int'(e.r1));
                        chk("busy_cycles", d, bcnt[d], 2 * rnd(d));
                        if (e.lat)
                            chk("latency", d, cyc - e.t0, 2 * rnd(d) + 1);
                        if (e.gap)
                            chk("b2b_gap", d, cyc - last_done[d], 2 * rnd(d) + 2);
                    end
                    bcnt[d]      = 0;
                    last_done[d] = cyc;
                end
            end
        end
    end

    task automatic go(
        input int d, input bit e,
        input logic [7:0] a, input logic [7:0] b,
        input logic [7:0] q0, input logic [7:0] q1,
        input logic [7:0] q2, input logic [7:0] q3,
        input logic [7:0] x0, input logic [7:0] x1
    );
        exp_t it;
        @(negedge clk);
        ed[d] = e;
        v0[d] = a;
        v1[d] = b;
        k0[d] = q0;
        k1[d] = q1;
        k2[d] = q2;
        k3[d] = q3;
        start[d] = 1'b1;
        it.r0 = x0;
        it.r1 = x1;
        it.t0 = cyc;
        it.lat = 1'b1;
        it.gap = 1'b0;
        sb[d].push_back(it);
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (done_w[d]) seen = 1'b1;
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL timeout dut%0d: got no done expected done", d);
        end
        @(posedge clk);
    endtask

    task automatic chk_zero(input string nm, input int d);
        chk({nm, "_busy"}, d, int'(busy_w[d]), 0);
        chk({nm, "_done"}, d, int'(done_w[d]), 0);
        chk({nm, "_r0"}, d, int'(r0_w[d]), 0);
        chk({nm, "_r1"}, d, int'(r1_w[d]), 0);
    endtask

    initial begin
        logic [15:0] m;
        exp_t it;
        int n0;
        nvec = 0;
        nerr = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            start[d] = 1'b0;
            ed[d] = 1'b0;
            k0[d] = '0;
            k1[d] = '0;
            k2[d] = '0;
            k3[d] = '0;
            v0[d] = '0;
            v1[d] = '0;
            ndone[d] = 0;
            bcnt[d] = 0;
            last_done[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset", 0);
        chk_zero("reset", 1);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        go(0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h1B);
        wait_done(0);
        go(0, 1'b1, 8'hB7, 8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_done(0);
        go(0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'hEA);
        wait_done(0);

        m = tea(1'b0, 32, 8'h01, 8'h23, 8'h45, 8'h67, 8'h12, 8'h34);
        go(1, 1'b0, 8'h12, 8'h34, 8'h01, 8'h23, 8'h45, 8'h67, m[15:8], m[7:0]);
        wait_done(1);
        go(1, 1'b1, m[15:8], m[7:0], 8'h01, 8'h23, 8'h45, 8'h67, 8'h12, 8'h34);
        wait_done(1);

        n0 = ndone[1];
        go(1, 1'b0, 8'h12, 8'h34, 8'h01, 8'h23, 8'h45, 8'h67, m[15:8], m[7:0]);
        for (int i = 0; i < 200; i++) begin
            if (!busy_w[1]) break;
            start[1] = ~start[1];
            ed[1] = ~ed[1];
            v0[1] = v0[1] ^ 8'hFF;
            k0[1] = k0[1] + 8'd1;
            @(posedge clk);
            #1;
        end
        start[1] = 1'b0;
        wait_done(1);
        repeat (10) @(posedge clk);
        chk("disturb_done_count", 1, ndone[1] - n0, 1);

        n0 = ndone[1];
        go(1, 1'b0, 8'h55, 8'hAA, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00);
        repeat (40) @(posedge clk);
        #1;
        sb[1].delete();
        rst[1] = 1'b1;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midreset", 1);
        rst[1] = 1'b0;
        start[1] = 1'b0;
        repeat (80) @(posedge clk);
        chk("abort_no_done", 1, ndone[1] - n0, 0);
        go(1, 1'b0, 8'h12, 8'h34, 8'h01, 8'h23, 8'h45, 8'h67, m[15:8], m[7:0]);
        wait_done(1);

        @(negedge clk);
        ed[1] = 1'b0;
        v0[1] = 8'h12;
        v1[1] = 8'h34;
        k0[1] = 8'h01;
        k1[1] = 8'h23;
        k2[1] = 8'h45;
        k3[1] = 8'h67;
        start[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            it.r0 = m[15:8];
            it.r1 = m[7:0];
            it.t0 = cyc;
            it.lat = (i == 0);
            it.gap = (i != 0);
            sb[1].push_back(it);
        end
        for (int i = 0; i < 3; i++) begin
            bit seen;
            seen = 1'b0;
            for (int j = 0; j < 600 && !seen; j++) begin
                @(negedge clk);
                if (done_w[1]) seen = 1'b1;
            end
            if (!seen) begin
                nvec++;
                nerr++;
                $display("FAIL b2b_timeout dut1: got no done expected done %0d", i);
            end
        end
        start[1] = 1'b0;
        repeat (80) @(posedge clk);

        chk("queue_left", 0, sb[0].size(), 0);
        chk("queue_left", 1, sb[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
